// File: rtl/rr_mux_arb.sv
// N-input word multiplexer with valid/ready handshakes and a one-beat registered output.
// MODE 0 forwards the externally selected channel; MODE 1 arbitrates round-robin.
module rr_mux_arb #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] data_p1;
    logic [SEL_W-1:0] chan_p1;
    logic             vld_p1;
    logic [SEL_W-1:0] last_grant;

    logic             load_en;
    logic             gnt_vld_p0;
    logic [SEL_W-1:0] gnt_p0;
    logic [WIDTH-1:0] mux_p0;

    logic             hi_found;
    logic [SEL_W-1:0] hi_idx;
    logic             lo_found;
    logic [SEL_W-1:0] lo_idx;

    assign load_en = !vld_p1 || out_ready;

    // Stage p0: grant selection. Round-robin prefers the first valid channel above
    // last_grant and falls back to the first valid one at or below it (wrap-around).
    always_comb begin
        gnt_vld_p0 = 1'b0;
        gnt_p0     = '0;
        hi_found   = 1'b0;
        hi_idx     = '0;
        lo_found   = 1'b0;
        lo_idx     = '0;
        if (MODE == 0) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (int'(sel) == i && in_valid[i]) begin
                    gnt_vld_p0 = 1'b1;
                    gnt_p0     = SEL_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (in_valid[i] && !hi_found && i > int'(last_grant)) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_W'(i);
                end
                if (in_valid[i] && !lo_found && i <= int'(last_grant)) begin
                    lo_found = 1'b1;
                    lo_idx   = SEL_W'(i);
                end
            end
            gnt_vld_p0 = hi_found || lo_found;
            gnt_p0     = hi_found ? hi_idx : lo_idx;
        end
    end

    always_comb begin
        in_ready = '0;
        mux_p0   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = load_en && gnt_vld_p0 && (int'(gnt_p0) == i);
            if (int'(gnt_p0) == i) begin
                mux_p0 = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Stage p1: output beat register. The pointer moves only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            chan_p1    <= '0;
            last_grant <= SEL_W'(NUM_IN - 1);
        end else if (load_en) begin
            vld_p1 <= gnt_vld_p0;
            if (gnt_vld_p0) begin
                data_p1 <= mux_p0;
                chan_p1 <= gnt_p0;
                if (MODE == 1) begin
                    last_grant <= gnt_p0;
                end
            end
        end
    end

    assign out_data  = data_p1;
    assign out_chan  = chan_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb: one MODE 0 and one MODE 1 instance, a cycle-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_rr_mux_arb;
    localparam int W = 32;
    localparam int N = 4;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N*W-1:0] d0, d1;
    logic [N-1:0]   v0, v1, rdy0, rdy1;
    logic [S-1:0]   s0, s1, oc0, oc1;
    logic [W-1:0]   od0, od1;
    logic           ov0, ov1, or0, or1;

    rr_mux_arb #(.WIDTH(W), .NUM_IN(N), .SEL_W(S), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(rdy0), .sel(s0),
        .out_data(od0), .out_chan(oc0), .out_valid(ov0), .out_ready(or0)
    );

    rr_mux_arb #(.WIDTH(W), .NUM_IN(N), .SEL_W(S), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(rdy1), .sel(s1),
        .out_data(od1), .out_chan(oc1), .out_valid(ov1), .out_ready(or1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model state per instance (0 = select mode, 1 = round-robin).
    bit          live = 1'b0;
    logic        mdl_vld[2], nxt_vld[2];
    logic [31:0] mdl_data[2], nxt_data[2];
    int          mdl_chan[2], nxt_chan[2];
    int          mdl_lg[2], nxt_lg[2];

    function automatic int grant(input int mode, input int lg, input logic [N-1:0] v, input int s);
        if (mode == 0) begin
            if (s < N && v[s]) return s;
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (lg + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic cmp_inst(input int m, input string tag, input logic [N-1:0] v,
                            input logic [N*W-1:0] d, input logic [S-1:0] s, input logic ordy,
                            input logic [N-1:0] rdy, input logic ov, input logic [W-1:0] od,
                            input logic [S-1:0] oc);
        int g;
        logic load;
        logic [N-1:0] er;
        g    = grant(m, mdl_lg[m], v, int'(s));
        load = !mdl_vld[m] || ordy;
        er   = (load && g >= 0) ? N'(1 << g) : '0;
        chk({tag, "_in_ready"}, 32'(rdy), 32'(er));
        chk({tag, "_out_valid"}, 32'(ov), 32'(mdl_vld[m]));
        chk({tag, "_out_data"}, od, mdl_data[m]);
        chk({tag, "_out_chan"}, 32'(oc), 32'(mdl_chan[m]));
        nxt_vld[m]  = mdl_vld[m];
        nxt_data[m] = mdl_data[m];
        nxt_chan[m] = mdl_chan[m];
        nxt_lg[m]   = mdl_lg[m];
        if (load) begin
            nxt_vld[m] = (g >= 0);
            if (g >= 0) begin
                nxt_data[m] = d[g*W +: W];
                nxt_chan[m] = g;
                if (m == 1) nxt_lg[m] = g;
            end
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            cmp_inst(0, "m0", v0, d0, s0, or0, rdy0, ov0, od0, oc0);
            cmp_inst(1, "m1", v1, d1, s1, or1, rdy1, ov1, od1, oc1);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            live <= 1'b1;
            for (int m = 0; m < 2; m++) begin
                mdl_vld[m]  <= 1'b0;
                mdl_data[m] <= '0;
                mdl_chan[m] <= 0;
                mdl_lg[m]   <= N - 1;
            end
        end else if (live) begin
            for (int m = 0; m < 2; m++) begin
                mdl_vld[m]  <= nxt_vld[m];
                mdl_data[m] <= nxt_data[m];
                mdl_chan[m] <= nxt_chan[m];
                mdl_lg[m]   <= nxt_lg[m];
            end
        end
    end

    int fair_seq[6]   = '{0, 1, 2, 3, 0, 1};
    int sparse_seq[4] = '{0, 3, 0, 3};

    initial begin
        v0 = '0; v1 = '0; s0 = '0; s1 = '0; or0 = 1'b1; or1 = 1'b1;
        d0 = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
        d1 = {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100};

        // Reset then idle
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_ov0", 32'(ov0), 0); chk("rst_od0", od0, 0); chk("rst_oc0", 32'(oc0), 0);
            chk("rst_rdy0", 32'(rdy0), 0);
            chk("rst_ov1", 32'(ov1), 0); chk("rst_od1", od1, 0); chk("rst_oc1", 32'(oc1), 0);
            chk("rst_rdy1", 32'(rdy1), 0);
        end
        rst = 1'b0;

        // Select mode: channel 2, then a select pointing at an idle channel
        s0 = 2'd2; v0 = 4'b1111;
        @(negedge clk); chk("sel2_rdy", 32'(rdy0), 32'b0100);
        @(posedge clk); #1;
        chk("sel2_od", od0, 32'hDEAD_BEEF); chk("sel2_oc", 32'(oc0), 2); chk("sel2_ov", 32'(ov0), 1);
        s0 = 2'd1; v0 = 4'b1101;
        @(negedge clk); chk("sel1_idle_rdy", 32'(rdy0), 0);
        @(posedge clk); #1;
        chk("sel1_idle_ov", 32'(ov0), 0); chk("sel1_hold_od", od0, 32'hDEAD_BEEF);
        chk("sel1_hold_oc", 32'(oc0), 2);
        v0 = '0;

        // Round-robin fairness with all channels requesting
        v1 = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("fair_oc", 32'(oc1), 32'(fair_seq[i]));
            chk("fair_od", od1, 32'h100 + 32'(fair_seq[i]));
            chk("fair_ov", 32'(ov1), 1);
        end

        // Sparse requests from a fresh pointer: only channels 0 and 3
        v1 = '0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; v1 = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("sparse_rdy_mid", 32'(rdy1 & 4'b0110), 0);
            @(posedge clk); #1;
            chk("sparse_oc", 32'(oc1), 32'(sparse_seq[i]));
            chk("sparse_od", od1, 32'h100 + 32'(sparse_seq[i]));
        end

        // Back-pressure: pointer sits at 3, so the next beat is channel 0, then frozen
        v1 = 4'b1111;
        @(posedge clk); #1;
        chk("bp_first_oc", 32'(oc1), 0);
        or1 = 1'b0;
        repeat (3) begin
            @(negedge clk); chk("bp_rdy", 32'(rdy1), 0);
            @(posedge clk); #1;
            chk("bp_oc", 32'(oc1), 0); chk("bp_od", od1, 32'h100); chk("bp_ov", 32'(ov1), 1);
        end
        or1 = 1'b1;
        @(negedge clk); chk("bp_release_rdy", 32'(rdy1), 32'b0010);
        @(posedge clk); #1;
        chk("bp_release_oc", 32'(oc1), 1); chk("bp_release_od", od1, 32'h101);

        // Reset while a beat is stalled
        or1 = 1'b0;
        @(posedge clk); #1;
        chk("stall_ov", 32'(ov1), 1); chk("stall_oc", 32'(oc1), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_stall_ov", 32'(ov1), 0); chk("rst_stall_od", od1, 0); chk("rst_stall_oc", 32'(oc1), 0);
        rst = 1'b0; or1 = 1'b1;
        @(negedge clk); chk("post_rst_rdy", 32'(rdy1), 32'b0001);
        @(posedge clk); #1;
        chk("post_rst_oc", 32'(oc1), 0); chk("post_rst_od", od1, 32'h100); chk("post_rst_ov", 32'(ov1), 1);

        v1 = '0;
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised N-input datapath multiplexer with valid/ready handshakes and a registered output.
- Generalises the fixed 4:1 word mux in three ways:
  - configurable channel count;
  - two modes, externally selected or round-robin arbitrated;
  - one-beat output buffering with back-pressure.
- Sits between multiple requesters (e.g. instruction/data fetch sources, debug port) and a single shared consumer in the FPGA datapath.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SEL_W, 2, select/channel-index width; must satisfy 2**SEL_W >= NUM_IN.
- MODE, 0, 0 = external select (sel port), 1 = round-robin arbitration (sel ignored).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; at most one bit high per cycle.
- sel  input  SEL_W  channel select, MODE 0 only.
- out_data  output  WIDTH  registered output word.
- out_chan  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer ready.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); evaluated only on the rising edge of clk.
- Reset values:
  - out_valid=0, out_data=0, out_chan=0.
  - Internal last_grant=NUM_IN-1, so channel 0 has first priority after reset.
- load_en = !out_valid | out_ready. This is combinational and gives full throughput: one beat per cycle.
- Grant, combinational:
  - MODE 0: g=sel if sel<NUM_IN and in_valid[sel]; otherwise no grant. sel>=NUM_IN never grants.
  - MODE 1: search channels starting at (last_grant+1) mod NUM_IN, wrapping around. The first channel with in_valid=1 is granted. No valid inputs means no grant.
- in_ready[g] = load_en & grant_exists. All other in_ready bits are 0.
- in_ready must not depend on out_valid of the same channel beyond load_en. No combinational path from in_ready to in_valid is assumed or required.
- Transfer accepted when in_valid[g] & in_ready[g]. On the next edge:
  - out_data <= in_data[g];
  - out_chan <= g;
  - out_valid <= 1;
  - in MODE 1 only, last_grant <= g.
- If load_en=1 and there is no grant, out_valid <= 0 on the next edge. out_data and out_chan hold their last values.
- If out_valid=1 and out_ready=0, out_data, out_chan and out_valid hold stable. All in_ready bits are 0.
- Latency: 1 cycle from input acceptance to out_valid.
- last_grant updates only on an accepted transfer. Stalled cycles do not advance the pointer, which preserves fairness.
- A requester whose in_valid drops before acceptance forfeits that slot. No state is recorded for it.
- rst asserted mid-operation discards any held beat (out_valid=0 next cycle) and restores last_grant. In-flight handshakes that cycle are not accepted.
- rst has priority over every other event on the same edge.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all in_valid=0 → out_valid=0, out_data=0, out_chan=0, in_ready=4'b0000 throughout.
- MODE 0 select: sel=2, in_valid=4'b1111, in_data ch2=32'hDEAD_BEEF, out_ready=1.
  - Required: in_ready=4'b0100.
  - Next cycle: out_data=32'hDEAD_BEEF, out_chan=2, out_valid=1.
  - Then set sel=1 with in_valid[1]=0 → out_valid drops to 0 next cycle.
- MODE 1 fairness: in_valid=4'b1111 held, out_ready=1, ch i data=i+32'h100.
  - Required out_chan sequence from reset: 0,1,2,3,0,1,…
  - out_data matches each channel; one beat per cycle.
- MODE 1 sparse/wrap: in_valid=4'b1001 held.
  - Required out_chan sequence: 0,3,0,3,…
  - Channels 1 and 2 never granted.
- Back-pressure: stream in MODE 1, deassert out_ready for 3 cycles while out_valid=1.
  - Required: out_data and out_chan frozen, in_ready=0, last_grant unchanged.
  - On out_ready=1, the pending beat is consumed and the next grant follows the frozen pointer (+1).
- Reset mid-stall: out_valid=1, out_ready=0, assert rst for 1 cycle → next cycle out_valid=0, out_data=0. The following grant is channel 0.
